// File: rtl/si5340_i2c_target_model.sv
// si5340_i2c_target_model: I2C target emulating the Si5340 register interface (16-bit pointer, byte registers).
// Optional feature macro SI5340_TARGET_AUTOINC_EN: pointer auto-increments after each written byte and each ACKed read byte.
module si5340_i2c_target_model #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h74,
    parameter int         MEM_DEPTH   = 256,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        scl_pad_i,
    input  logic        sda_pad_i,
    output logic        sda_pad_o,
    output logic        sda_padoen_o,
    output logic        wr_valid_o,
    output logic [15:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        busy_o
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);
`ifdef SI5340_TARGET_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, PTR_HI, ACK_HI, PTR_LO, ACK_LO,
        WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t            state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic              scl_prev_q, sda_prev_q;
    logic [7:0]        sh_q;
    logic [2:0]        cnt_q;
    logic              ack_q, rw_q, oen_q, busy_q, wr_valid_q;
    logic [15:0]       ptr_q, wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        mem_q [MEM_DEPTH];

    logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
    logic in_range, wr_fire, ack_rd;
    logic [7:0] byte_nx, rd_byte;
    logic [15:0] ptr_nx;
    state_t ack_nx;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    // Start/stop only count while SCL was high on both samples, so an SCL edge never fakes one.
    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_nx  = {sh_q[6:0], sda_s};
    assign in_range = {1'b0, ptr_q} < DEPTH;
    assign rd_byte  = in_range ? mem_q[ptr_q[AW-1:0]] : 8'hFF;
    assign ptr_nx   = AUTOINC ? ptr_q + 16'd1 : ptr_q;
    assign ack_rd   = state_q == DEV_ACK && rw_q;
    assign ack_nx   = state_q == DEV_ACK ? (rw_q ? RD_DATA : PTR_HI)
                    : state_q == ACK_HI  ? PTR_LO : WR_DATA;
    assign wr_fire  = !rst_i && !start_ev && !stop_ev && state_q == WR_DATA && scl_rise && cnt_q == 3'd7;

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = oen_q;
    assign wr_valid_o   = wr_valid_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign busy_o       = busy_q;

    // Pad synchronisers plus one delayed copy for edge detection; reset high so an idle bus shows no edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_pad_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_pad_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // Register array: written only by a completed in-range data byte, never reset.
    always_ff @(posedge clk_i) begin
        if (wr_fire && in_range) mem_q[ptr_q[AW-1:0]] <= byte_nx;
    end

    // Protocol FSM; ack_q marks the second half of an ACK slot (or a controller ACK awaiting the falling edge).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            oen_q      <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            if (start_ev) begin
                state_q <= DEV_ADDR;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
                oen_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else if (stop_ev) begin
                state_q <= IDLE;
                ack_q   <= 1'b0;
                oen_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    DEV_ADDR, PTR_HI, PTR_LO, WR_DATA: begin
                        if (scl_rise) begin
                            sh_q  <= byte_nx;
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                case (state_q)
                                    DEV_ADDR: begin
                                        if (byte_nx[7:1] == SLAVE_ADDR) begin
                                            state_q <= DEV_ACK;
                                            busy_q  <= 1'b1;
                                            rw_q    <= byte_nx[0];
                                        end else begin
                                            state_q <= WAIT_STOP;
                                        end
                                    end
                                    PTR_HI: begin
                                        ptr_q[15:8] <= byte_nx;
                                        state_q     <= ACK_HI;
                                    end
                                    PTR_LO: begin
                                        ptr_q[7:0] <= byte_nx;
                                        state_q    <= ACK_LO;
                                    end
                                    default: begin
                                        wr_valid_q <= 1'b1;
                                        wr_addr_q  <= ptr_q;
                                        wr_data_q  <= byte_nx;
                                        ptr_q      <= ptr_nx;
                                        state_q    <= ACK_WR;
                                    end
                                endcase
                            end
                        end
                    end
                    DEV_ACK, ACK_HI, ACK_LO, ACK_WR: begin
                        if (scl_fall) begin
                            ack_q <= ~ack_q;
                            if (!ack_q) begin
                                oen_q <= 1'b0;
                            end else begin
                                state_q <= ack_nx;
                                oen_q   <= ack_rd ? rd_byte[7] : 1'b1;
                                sh_q    <= rd_byte;
                                cnt_q   <= '0;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            cnt_q <= cnt_q + 3'd1;
                            sh_q  <= sh_q << 1;
                            oen_q <= cnt_q == 3'd7 ? 1'b1 : sh_q[6];
                            if (cnt_q == 3'd7) state_q <= RD_ACK;
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && !ack_q) begin
                            if (sda_s) begin
                                state_q <= WAIT_STOP;
                            end else begin
                                ack_q <= 1'b1;
                                ptr_q <= ptr_nx;
                            end
                        end else if (scl_fall && ack_q) begin
                            ack_q   <= 1'b0;
                            oen_q   <= rd_byte[7];
                            sh_q    <= rd_byte;
                            cnt_q   <= '0;
                            state_q <= RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_si5340_i2c_target_model.sv
// tb_si5340_i2c_target_model: directed I2C controller bench for the Si5340 target model.
module tb_si5340_i2c_target_model;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic sda_pad_o, sda_padoen_o, wr_valid_o, busy_o;
    logic [15:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic sda_line;
    int checks = 0, errors = 0, wr_cnt = 0, base;
    logic [15:0] last_addr;
    logic [7:0] last_data, d;
    logic [4:0] wacks;
    logic [3:0] racks;
    logic a0, a1, a2, a3, s;

    si5340_i2c_target_model dut (
        .clk_i(clk), .rst_i(rst), .scl_pad_i(scl), .sda_pad_i(sda_line),
        .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .wr_valid_o(wr_valid_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
    );

    assign sda_line = sda_m & (sda_padoen_o ? 1'b1 : sda_pad_o);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_valid_o) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= wr_addr_o;
            last_data <= wr_data_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic qd;
        repeat (8) @(posedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic smp);
        sda_m = b; qd;
        scl = 1'b1; qd;
        smp = sda_line; qd;
        scl = 1'b0; qd;
    endtask

    task automatic i_start;
        sda_m = 1'b1; qd;
        scl = 1'b1; qd;
        sda_m = 1'b0; qd;
        scl = 1'b0; qd;
    endtask

    task automatic i_stop;
        sda_m = 1'b0; qd;
        scl = 1'b1; qd;
        sda_m = 1'b1; qd;
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic t;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], t);
        bus_bit(1'b1, t);
        ack = ~t;
    endtask

    task automatic rbyte(input logic ack, output logic [7:0] v);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, t);
            v[i] = t;
        end
        bus_bit(~ack, t);
    endtask

    task automatic wr_reg(input logic [15:0] p, input logic [7:0] x, input logic [7:0] y, input int n, output logic [4:0] ak);
        logic k4, k3, k2, k1, k0;
        i_start;
        wbyte(8'hE8, k4); wbyte(p[15:8], k3); wbyte(p[7:0], k2); wbyte(x, k1);
        k0 = 1'b1;
        if (n > 1) wbyte(y, k0);
        i_stop;
        ak = {k4, k3, k2, k1, k0};
    endtask

    task automatic rd_reg(input logic [15:0] p, output logic [7:0] v, output logic [3:0] ak);
        logic k3, k2, k1, k0;
        i_start;
        wbyte(8'hE8, k3); wbyte(p[15:8], k2); wbyte(p[7:0], k1);
        i_start;
        wbyte(8'hE9, k0);
        rbyte(1'b0, v);
        i_stop;
        ak = {k3, k2, k1, k0};
    endtask

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_oen", 32'(sda_padoen_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data_o), 32'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_oen", 32'(sda_padoen_o), 32'd1);

        // T1: single write 0x0012 <- 0xA5
        base = wr_cnt;
        i_start;
        wbyte(8'hE8, a0);
        @(negedge clk);
        chk("t1_busy_hi", 32'(busy_o), 32'd1);
        wbyte(8'h00, a1); wbyte(8'h12, a2); wbyte(8'hA5, a3);
        i_stop;
        @(negedge clk);
        chk("t1_acks", 32'({a0, a1, a2, a3}), 32'hF);
        chk("t1_wr_cnt", 32'(wr_cnt - base), 32'd1);
        chk("t1_wr_addr", 32'(last_addr), 32'h0012);
        chk("t1_wr_data", 32'(last_data), 32'hA5);
        chk("t1_busy_lo", 32'(busy_o), 32'd0);

        // T2: pointer write, repeated start, read with NACK
        i_start;
        wbyte(8'hE8, a0); wbyte(8'h00, a1); wbyte(8'h12, a2);
        i_start;
        wbyte(8'hE9, a3);
        rbyte(1'b0, d);
        i_stop;
        @(negedge clk);
        chk("t2_acks", 32'({a0, a1, a2, a3}), 32'hF);
        chk("t2_rd_data", 32'(d), 32'hA5);
        chk("t2_oen", 32'(sda_padoen_o), 32'd1);
        chk("t2_busy", 32'(busy_o), 32'd0);

        // T3: wrong address is NACKed and ignored
        base = wr_cnt;
        i_start;
        wbyte(8'hEA, a0);
        @(negedge clk);
        chk("t3_busy", 32'(busy_o), 32'd0);
        wbyte(8'h00, a1); wbyte(8'h12, a2); wbyte(8'h5A, a3);
        i_stop;
        @(negedge clk);
        chk("t3_acks", 32'({a0, a1, a2, a3}), 32'h0);
        chk("t3_wr_cnt", 32'(wr_cnt - base), 32'd0);
        rd_reg(16'h0012, d, racks);
        chk("t3_mem_kept", 32'(d), 32'hA5);

        // T4: out-of-range pointer reads 0xFF, writes are reported but do not alias
        wr_reg(16'h0000, 8'h77, 8'h00, 1, wacks);
        chk("t4_seed_acks", 32'(wacks), 32'h1F);
        rd_reg(16'h0200, d, racks);
        chk("t4_rd_acks", 32'(racks), 32'hF);
        chk("t4_rd_ff", 32'(d), 32'hFF);
        base = wr_cnt;
        wr_reg(16'h0200, 8'h33, 8'h00, 1, wacks);
        @(negedge clk);
        chk("t4_wr_acks", 32'(wacks), 32'h1F);
        chk("t4_wr_cnt", 32'(wr_cnt - base), 32'd1);
        chk("t4_wr_addr", 32'(last_addr), 32'h0200);
        chk("t4_wr_data", 32'(last_data), 32'h33);
        rd_reg(16'h0000, d, racks);
        chk("t4_no_alias", 32'(d), 32'h77);

        // T5: start mid-PTR_LO aborts, then a clean write
        base = wr_cnt;
        i_start;
        wbyte(8'hE8, a0); wbyte(8'h00, a1);
        for (int i = 0; i < 4; i++) bus_bit(1'b0, s);
        i_start;
        wbyte(8'hE8, a0); wbyte(8'h00, a1); wbyte(8'h05, a2); wbyte(8'h3C, a3);
        i_stop;
        @(negedge clk);
        chk("t5_acks", 32'({a0, a1, a2, a3}), 32'hF);
        chk("t5_wr_cnt", 32'(wr_cnt - base), 32'd1);
        chk("t5_wr_addr", 32'(last_addr), 32'h0005);
        chk("t5_wr_data", 32'(last_data), 32'h3C);
        rd_reg(16'h0005, d, racks);
        chk("t5_readback", 32'(d), 32'h3C);

        // T6: two-byte write, pointer behaviour depends on auto-increment
        base = wr_cnt;
        wr_reg(16'h0010, 8'h11, 8'h22, 2, wacks);
        @(negedge clk);
        chk("t6_acks", 32'(wacks), 32'h1F);
        chk("t6_wr_cnt", 32'(wr_cnt - base), 32'd2);
        chk("t6_wr_data", 32'(last_data), 32'h22);
        rd_reg(16'h0010, d, racks);
`ifdef SI5340_TARGET_AUTOINC_EN
        chk("t6_wr_addr", 32'(last_addr), 32'h0011);
        chk("t6_rd_0010", 32'(d), 32'h11);
        rd_reg(16'h0011, d, racks);
        chk("t6_rd_0011", 32'(d), 32'h22);
`else
        chk("t6_wr_addr", 32'(last_addr), 32'h0010);
        chk("t6_rd_0010", 32'(d), 32'h22);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/si5340_i2c_target_model.md
Name: si5340_i2c_target_model

Overview:
I2C target (responder) that emulates the Si5340 register interface at the far end of the bus driven by the config loader.
- Decodes START/STOP, matches a 7-bit device address, and accepts a 16-bit register pointer (high byte, then low byte) followed by data bytes.
- Stores written bytes in an internal register array and returns them on read transactions.
- Each completed write is also reported on a strobe port, so benches and board-level loopback checks can score loader traffic.

Parameters:
SLAVE_ADDR, 7'h74, device address this target ACKs.
MEM_DEPTH, 256, number of 8-bit registers; indexed by ptr[$clog2(MEM_DEPTH)-1:0].
SYNC_STAGES, 2, synchroniser depth on scl_pad_i/sda_pad_i (minimum 2).

Ports:
clk_i  in  1  system clock; must be at least 16x SCL frequency.
rst_i  in  1  synchronous, active-high reset.
scl_pad_i  in  1  SCL line input.
sda_pad_i  in  1  SDA line input.
sda_pad_o  out  1  SDA output value; tied to 1'b0.
sda_padoen_o  out  1  SDA output enable, active low (0 = pull low).
wr_valid_o  out  1  one-cycle pulse when a data byte is written.
wr_addr_o  out  16  register pointer of that write.
wr_data_o  out  8  data of that write.
busy_o  out  1  high from an address-matched START until STOP or abort.

Behaviour:
- Reset (rst_i high at a clk_i edge), applies immediately, including mid-transfer:
  - state=IDLE, sda_padoen_o=1, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, ptr=0.
  - Register array contents are not reset.
- Input conditioning:
  - SCL/SDA pass through SYNC_STAGES flops, then a 1-cycle edge detect.
  - Event latency from pad to FSM is SYNC_STAGES+1 clocks.
- Bus events:
  - START/Sr = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - SDA is sampled on SCL rising edges. The target changes SDA only on SCL falling edges.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, PTR_HI, ACK_HI, PTR_LO, ACK_LO, WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP.
- DEV_ADDR:
  - Shift in 8 bits, MSB first.
  - On a match with SLAVE_ADDR, go to DEV_ACK and set busy_o=1.
  - On a mismatch, go to WAIT_STOP with SDA released (NACK).
- Write path:
  - DEV_ACK(R/W=0) -> PTR_HI -> ACK_HI -> PTR_LO -> ACK_LO -> WR_DATA -> ACK_WR -> WR_DATA ...
  - ptr[15:8] loads at the end of PTR_HI; ptr[7:0] loads at the end of PTR_LO.
- ACK timing: on the SCL falling edge after the 8th bit, drive sda_padoen_o=0; release it on the next SCL falling edge. Every byte addressed to this target is ACKed, including out-of-range pointers.
- Byte completion (the clock after the 8th SCL rising edge of a data byte):
  - wr_valid_o=1 for exactly one clock, wr_addr_o=ptr, wr_data_o=byte.
  - If ptr < MEM_DEPTH, mem[ptr] <= byte. Otherwise the array is unchanged.
- Read path:
  - DEV_ACK(R/W=1) -> RD_DATA. The byte is mem[ptr], or 8'hFF if ptr >= MEM_DEPTH.
  - The MSB is driven on the SCL falling edge that ends the ACK; each further bit is driven on successive falling edges. A 1 bit means released (oen=1).
  - After bit 0, release SDA and sample the controller's ACK on the SCL rising edge.
  - ACK (0): reload and go to RD_DATA. NACK (1): go to WAIT_STOP.
- Pointer persistence: ptr survives STOP. A START+addrW+ptrH+ptrL+STOP followed by START+addrR reads from that ptr. Sr may replace STOP.
- Boundaries:
  - START or Sr in any state (mid-byte included): abort the current byte, release SDA within 1 clock, go to DEV_ADDR. A partial byte is never written.
  - STOP in any state: release SDA, busy_o=0, go to IDLE. No wr_valid_o for a partial byte.
  - WAIT_STOP ignores all bits until START or STOP.
  - SCL/SDA both high after reset: stay in IDLE; no false START is detected.

Optional Feature:
Macro SI5340_TARGET_AUTOINC_EN.
- Defined: ptr increments by 1 after each written data byte (after the write) and after each read byte is ACKed by the controller. Wraps 16'hFFFF -> 16'h0000.
- Undefined: ptr is fixed after PTR_LO. Successive write bytes overwrite the same register, and successive read bytes return the same register.

Test Plan:
1. Write 0x74/W, 0x00, 0x12, 0xA5, STOP -> four ACKs; single wr_valid_o pulse with addr 0x0012, data 0xA5; busy_o falls at STOP.
2. After test 1: 0x74/W, 0x00, 0x12, Sr, 0x74/R, controller NACK, STOP -> SDA carries 0xA5 MSB-first; sda_padoen_o=1 after STOP.
3. 0x75/W, 0x00, 0x12, 0x5A, STOP -> address NACK; no wr_valid_o; busy_o stays 0; mem[0x12] remains 0xA5.
4. Read ptr 0x0200 with MEM_DEPTH=256 -> 0xFF returned; write 0x33 to 0x0200 -> ACK and wr_valid_o pulse, mem unchanged.
5. START after 4 bits of PTR_LO, then a full write 0x0005 <- 0x3C -> first transfer aborted with no write; only addr 0x0005, data 0x3C reported.
6. Write 0x0010 with bytes 0x11, 0x22 -> AUTOINC_EN: writes to 0x0010 and 0x0011; without it: two writes to 0x0010, final value 0x22.
